// File: rtl/port_sext_pkg.sv
// Shared types and helpers for the port sign-extension accumulator.
// State encoding, the signed-overflow test and two's-complement limits.
package port_sext_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Signed overflow: operands share a sign and the sum's sign differs from it.
  function automatic logic ovf_add(input logic a, input logic b, input logic sum);
    return (a == b) && (sum != a);
  endfunction

  function automatic logic [63:0] smax(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] smin(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/port_sext_ext.sv
// Combinational IN_W -> OUT_W widener; sign-extends when IN_SIGNED=1, else zero-extends.
module port_sext_ext
  import port_sext_pkg::*;
#(
  parameter int IN_W      = 4,
  parameter int OUT_W     = 8,
  parameter int IN_SIGNED = 1
) (
  input  logic [IN_W-1:0]         in_data,
  output logic signed [OUT_W-1:0] ext_data
);

  if (IN_SIGNED != 0) begin : g_sext
    assign ext_data = {{(OUT_W - IN_W){in_data[IN_W-1]}}, in_data};
  end else begin : g_zext
    assign ext_data = {{(OUT_W - IN_W){1'b0}}, in_data};
  end

endmodule

// File: rtl/port_sext_accum.sv
// Accumulates COUNT widened samples and offers the signed total on a valid/ready port.
// Build option PORT_SEXT_SAT_EN: saturate the accumulator on signed overflow instead of wrapping.
//
// state | meaning
// ACC   | accepting samples, summing into acc
// HOLD  | result presented, waiting for out_ready
module port_sext_accum
  import port_sext_pkg::*;
#(
  parameter int IN_W      = 4,
  parameter int OUT_W     = 8,
  parameter int IN_SIGNED = 1,
  parameter int COUNT     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf
);

  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

  state_t           state, state_nx;
  logic [OUT_W-1:0] acc, ext, sum, acc_nx;
  logic [CNT_W-1:0] cnt;
  logic             sticky, accept, last_beat, beat_ovf;

  port_sext_ext #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .IN_SIGNED (IN_SIGNED)
  ) u_ext (
    .in_data  (in_data),
    .ext_data (ext)
  );

  assign sum      = acc + ext;
  assign beat_ovf = ovf_add(acc[OUT_W-1], ext[OUT_W-1], sum[OUT_W-1]);

`ifdef PORT_SEXT_SAT_EN
  localparam logic [OUT_W-1:0] SAT_MAX = OUT_W'(smax(OUT_W));
  localparam logic [OUT_W-1:0] SAT_MIN = OUT_W'(smin(OUT_W));
  // Overflow direction follows the addend's sign, since both operands agree.
  assign acc_nx = beat_ovf ? (ext[OUT_W-1] ? SAT_MIN : SAT_MAX) : sum;
`else
  assign acc_nx = sum;
`endif

  assign in_ready  = (state == ACC);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt == LAST_CNT);

  always_comb begin
    state_nx = state;
    case (state)
      ACC:     if (accept && last_beat) state_nx = HOLD;
      HOLD:    if (out_ready) state_nx = ACC;
      default: state_nx = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACC;
      acc      <= '0;
      cnt      <= '0;
      sticky   <= 1'b0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        ACC: begin
          if (accept) begin
            acc    <= acc_nx;
            cnt    <= cnt + CNT_W'(1);
            sticky <= sticky | beat_ovf;
            if (last_beat) begin
              out_data <= acc_nx;
              out_ovf  <= sticky | beat_ovf;
            end
          end
        end
        HOLD: begin
          // Output registers keep the last result; only the running sum restarts.
          if (out_ready) begin
            acc    <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_port_sext_accum.sv
// Directed self-checking bench: four accumulator instances covering signedness and COUNT.
module tb_port_sext_accum;

  logic       clk;
  logic       rst_n;
  logic       in_valid  [4];
  logic       in_ready  [4];
  logic [3:0] in_data   [4];
  logic       out_valid [4];
  logic       out_ready [4];
  logic [7:0] out_data  [4];
  logic       out_ovf   [4];

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: signed COUNT=4, 1: unsigned COUNT=4, 2: signed COUNT=20, 3: signed COUNT=1
  port_sext_accum #(.IN_W(4), .OUT_W(8), .IN_SIGNED(1), .COUNT(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_ovf(out_ovf[0]));
  port_sext_accum #(.IN_W(4), .OUT_W(8), .IN_SIGNED(0), .COUNT(4)) u_u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_ovf(out_ovf[1]));
  port_sext_accum #(.IN_W(4), .OUT_W(8), .IN_SIGNED(1), .COUNT(20)) u_s20 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(out_data[2]), .out_ovf(out_ovf[2]));
  port_sext_accum #(.IN_W(4), .OUT_W(8), .IN_SIGNED(1), .COUNT(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_data(in_data[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .out_data(out_data[3]), .out_ovf(out_ovf[3]));

  typedef struct {
    string      name;
    int         sel;
    logic [3:0] data;
    int         beats;
    logic [7:0] exp_data;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Offer `beats` samples of `d`, then check latency, result and release.
  task automatic run_vec(input string name, input int sel, input logic [3:0] d,
                         input int beats, input logic [7:0] exp_d, input logic exp_o);
    for (int i = 0; i < beats; i++) begin
      @(negedge clk);
      if (i == 0) chk({name, "_in_ready"}, 32'(in_ready[sel]), 32'd1);
      if (i == beats - 1) chk({name, "_early_valid"}, 32'(out_valid[sel]), 32'd0);
      in_valid[sel] = 1'b1;
      in_data[sel]  = d;
      @(posedge clk);
      #1 in_valid[sel] = 1'b0;
    end
    @(negedge clk);
    chk({name, "_out_valid"}, 32'(out_valid[sel]), 32'd1);
    chk({name, "_out_data"}, 32'(out_data[sel]), 32'(exp_d));
    chk({name, "_out_ovf"}, 32'(out_ovf[sel]), 32'(exp_o));
    out_ready[sel] = 1'b1;
    @(posedge clk);
    #1 out_ready[sel] = 1'b0;
    @(negedge clk);
    chk({name, "_released"}, 32'(out_valid[sel]), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{"s_neg3",   0, 4'hD, 4,  8'hF4, 1'b0};
    vecs[1]  = '{"u_13",     1, 4'hD, 4,  8'h34, 1'b0};
`ifdef PORT_SEXT_SAT_EN
    vecs[2]  = '{"s20_pos7", 2, 4'h7, 20, 8'h7F, 1'b1};
    vecs[3]  = '{"s20_neg8", 2, 4'h8, 20, 8'h80, 1'b1};
`else
    vecs[2]  = '{"s20_pos7", 2, 4'h7, 20, 8'h8C, 1'b1};
    vecs[3]  = '{"s20_neg8", 2, 4'h8, 20, 8'h60, 1'b1};
`endif
    vecs[4]  = '{"s20_neg1", 2, 4'hF, 20, 8'hEC, 1'b0};
    vecs[5]  = '{"s_pos7",   0, 4'h7, 4,  8'h1C, 1'b0};
    vecs[6]  = '{"s_neg8",   0, 4'h8, 4,  8'hE0, 1'b0};
    vecs[7]  = '{"u_15",     1, 4'hF, 4,  8'h3C, 1'b0};
    vecs[8]  = '{"u_zero",   1, 4'h0, 4,  8'h00, 1'b0};
    vecs[9]  = '{"s1_neg8",  3, 4'h8, 1,  8'hF8, 1'b0};
    vecs[10] = '{"s1_pos7",  3, 4'h7, 1,  8'h07, 1'b0};

    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid[k]  = 1'b0;
      in_data[k]   = 4'h0;
      out_ready[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("rst_in_ready",  32'(in_ready[k]),  32'd1);
      chk("rst_out_valid", 32'(out_valid[k]), 32'd0);
      chk("rst_out_data",  32'(out_data[k]),  32'd0);
      chk("rst_out_ovf",   32'(out_ovf[k]),   32'd0);
    end
    rst_n = 1'b1;

    for (int v = 0; v < 11; v++)
      run_vec(vecs[v].name, vecs[v].sel, vecs[v].data, vecs[v].beats,
              vecs[v].exp_data, vecs[v].exp_ovf);

    // Backpressure: result of 4x1 held while in_valid stays high with other data.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid[0] = 1'b1;
      in_data[0]  = 4'h1;
    end
    @(negedge clk);
    in_data[0] = 4'h5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready",  32'(in_ready[0]),  32'd0);
      chk("bp_out_valid", 32'(out_valid[0]), 32'd1);
      chk("bp_out_data",  32'(out_data[0]),  32'h04);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    chk("bp_resume_ready", 32'(in_ready[0]), 32'd1);
    repeat (3) @(negedge clk);
    chk("bp_not_early", 32'(out_valid[0]), 32'd0);
    @(negedge clk);
    in_valid[0] = 1'b0;
    chk("bp_new_valid", 32'(out_valid[0]), 32'd1);
    chk("bp_new_sum",   32'(out_data[0]),  32'h14);
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;

    // Reset mid-sum discards partial sum and count.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid[0] = 1'b1;
      in_data[0]  = 4'h3;
    end
    @(negedge clk);
    in_valid[0] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("rst_mid", 0, 4'h1, 4, 8'h04, 1'b0);

    // Asynchronous reset takes effect without a clock edge.
    @(negedge clk);
    in_valid[3] = 1'b1;
    in_data[3]  = 4'h2;
    @(negedge clk);
    in_valid[3] = 1'b0;
    chk("async_pre_valid", 32'(out_valid[3]), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_out_valid", 32'(out_valid[3]), 32'd0);
    chk("async_in_ready", 32'(in_ready[3]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // COUNT=1 back-to-back: result/idle alternation with in_valid and out_ready high.
    @(negedge clk);
    in_valid[3]  = 1'b1;
    in_data[3]   = 4'h8;
    out_ready[3] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("b2b_out_valid", 32'(out_valid[3]), (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k % 2 == 0) chk("b2b_out_data", 32'(out_data[3]), 32'hF8);
    end
    in_valid[3]  = 1'b0;
    out_ready[3] = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
